// File: rtl/pkg_en.sv
// Shared token and state types for the store write-buffer.
// Contents:
//   FTk_t       - forward token from the store sequencer (v, r, c, d)
//   BTk_t       - back-propagated token to the sequencer (n, t, v, c)
//   WBufState_t - write-buffer controller states
package pkg_en;

   localparam int FTK_DATA_W = 32;

   typedef struct packed {
      logic                  v;   // token valid
      logic                  r;   // release: last store of the access
      logic                  c;   // sideband tag carried with the entry
      logic [FTK_DATA_W-1:0] d;   // store data
   } FTk_t;

   typedef struct packed {
      logic n;   // not-ready: sequencer must hold further stores
      logic t;   // access terminated, buffer fully written back
      logic v;
      logic c;
   } BTk_t;

   typedef enum logic [1:0] {
      WB_IDLE  = 2'd0,
      WB_FILL  = 2'd1,
      WB_DRAIN = 2'd2,
      WB_DONE  = 2'd3
   } WBufState_t;

endpackage

// File: rtl/cram_st_wbuf_if.sv
// Store-sequencer handshake bundle for cram_st_wbuf.
// Signals:
//   I_St_Req    - store request
//   I_St_Addr   - store address
//   I_St_FTk    - forward token (v, r, c, d)
//   I_AccessEnd - end-of-access pulse
//   O_St_BTk    - back-propagated token from the buffer
// Modports: master (sequencer side), slave (write buffer side).
interface cram_st_wbuf_if #(
   parameter int WIDTH_ADDR = 8
);
   logic                  I_St_Req;
   logic [WIDTH_ADDR-1:0] I_St_Addr;
   pkg_en::FTk_t          I_St_FTk;
   logic                  I_AccessEnd;
   pkg_en::BTk_t          O_St_BTk;

   modport master (
      output I_St_Req, I_St_Addr, I_St_FTk, I_AccessEnd,
      input  O_St_BTk
   );

   modport slave (
      input  I_St_Req, I_St_Addr, I_St_FTk, I_AccessEnd,
      output O_St_BTk
   );
endinterface

// File: rtl/cram_wbuf_fifo.sv
// Circular FIFO holding write-buffer entries.
// Ports:
//   clock, reset   - clock and asynchronous active-low reset
//   push, pop      - enqueue din / dequeue head (both allowed when full)
//   din, dout      - entry in, head entry out (combinational read)
//   full, empty    - occupancy flags
//   count          - number of occupied entries
// Stored words are not cleared on reset; the pointers and count are,
// which discards any buffered entry.
module cram_wbuf_fifo #(
   parameter int WIDTH = 42,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wptr_r;
   logic [AW-1:0]    rptr_r;
   logic [AW:0]      count_r;

   // Entry storage write port
   always_ff @(posedge clock) begin
      if (push) begin
         mem_r[wptr_r] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (push) begin
            wptr_r <= wptr_r + AW'(1);
         end
         if (pop) begin
            rptr_r <= rptr_r + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign dout  = mem_r[rptr_r];
   assign full  = (count_r == (AW+1)'(DEPTH));
   assign empty = (count_r == '0);
   assign count = count_r;
endmodule

// File: rtl/cram_st_wbuf.sv
// Store write buffer between the store sequencer and a RAM write port.
// Ports:
//   clock, reset  - clock and asynchronous active-low reset
//   st            - store handshake (cram_st_wbuf_if.slave)
//   I_Ld_Busy     - load side owns the RAM port; writes stall
//   O_We/O_Addr/O_Data - registered RAM write port
//   O_Count       - occupied entries
//   O_Err         - sticky overflow (dropped push)
//   O_Busy        - controller not idle
// A push arriving at an empty buffer while the RAM port is free is written
// straight through, giving a one-cycle push-to-write latency.
module cram_st_wbuf
   import pkg_en::*;
#(
   parameter int WIDTH_DATA = 32,
   parameter int WIDTH_ADDR = 8,
   parameter int DEPTH      = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   cram_st_wbuf_if.slave           st,
   input  logic                    I_Ld_Busy,
   output logic                    O_We,
   output logic [WIDTH_ADDR-1:0]   O_Addr,
   output logic [WIDTH_DATA-1:0]   O_Data,
   output logic [$clog2(DEPTH):0]  O_Count,
   output logic                    O_Err,
   output logic                    O_Busy
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = WIDTH_ADDR + WIDTH_DATA + 2;

   WBufState_t      state_r;
   WBufState_t      state_nxt_s;
   logic            push_req_s;
   logic            accept_s;
   logic            pop_s;
   logic            bypass_s;
   logic            fifo_full_s;
   logic            fifo_empty_s;
   logic [CW-1:0]   count_s;
   logic [EW-1:0]   in_entry_s;
   logic [EW-1:0]   head_entry_s;
   logic [EW-1:0]   wr_entry_s;
   logic            err_r;
   logic            unused_tag_bits_s;

   // Entry layout: {addr, data, c, r}
   assign in_entry_s = {st.I_St_Addr, WIDTH_DATA'(st.I_St_FTk.d),
                        st.I_St_FTk.c, st.I_St_FTk.r};

   assign push_req_s = st.I_St_Req & st.I_St_FTk.v &
                       ((state_r == WB_IDLE) | (state_r == WB_FILL));
   // Full only implies non-empty, so accept_s never feeds back into pop_s
   assign pop_s      = ~I_Ld_Busy & (~fifo_empty_s | push_req_s);
   assign accept_s   = push_req_s & (~fifo_full_s | pop_s);
   assign bypass_s   = fifo_empty_s & pop_s;

   cram_wbuf_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (accept_s & ~bypass_s),
      .pop   (pop_s & ~fifo_empty_s),
      .din   (in_entry_s),
      .dout  (head_entry_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (count_s)
   );

   // Select the entry to write: incoming store when bypassing an empty buffer
   always_comb begin
      wr_entry_s = head_entry_s;
      if (bypass_s) begin
         wr_entry_s = in_entry_s;
      end else begin
         wr_entry_s = head_entry_s;
      end
   end

   assign unused_tag_bits_s = ^wr_entry_s[1:0];

   // RAM write port registers; address and data hold when idle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         O_We   <= 1'b0;
         O_Addr <= '0;
         O_Data <= '0;
      end else if (pop_s) begin
         O_We   <= 1'b1;
         O_Addr <= wr_entry_s[EW-1 -: WIDTH_ADDR];
         O_Data <= wr_entry_s[WIDTH_DATA+1 -: WIDTH_DATA];
      end else begin
         O_We   <= 1'b0;
      end
   end

   // Sticky overflow flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_r <= 1'b0;
      end else if (push_req_s & ~accept_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   // Controller next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         WB_IDLE: begin
            if (accept_s) begin
               if (st.I_St_FTk.r | st.I_AccessEnd) begin
                  state_nxt_s = WB_DRAIN;
               end else begin
                  state_nxt_s = WB_FILL;
               end
            end else begin
               state_nxt_s = WB_IDLE;
            end
         end
         WB_FILL: begin
            if (st.I_AccessEnd | (accept_s & st.I_St_FTk.r)) begin
               state_nxt_s = WB_DRAIN;
            end else begin
               state_nxt_s = WB_FILL;
            end
         end
         WB_DRAIN: begin
            if (fifo_empty_s & ~O_We) begin
               state_nxt_s = WB_DONE;
            end else begin
               state_nxt_s = WB_DRAIN;
            end
         end
         WB_DONE:  state_nxt_s = WB_IDLE;
         default:  state_nxt_s = WB_IDLE;
      endcase
   end

   // Controller state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= WB_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   assign st.O_St_BTk = '{n: ((count_s >= CW'(DEPTH - 1)) |
                              (state_r == WB_DRAIN) | (state_r == WB_DONE)),
                          t: (state_r == WB_DONE),
                          v: 1'b0,
                          c: 1'b0};
   assign O_Count = count_s;
   assign O_Err   = err_r;
   assign O_Busy  = (state_r != WB_IDLE);
endmodule

// File: doc/cram_st_wbuf.md
CRAM_ST_WBUF -- requirements
Module: cram_st_wbuf

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 32, data word width.
REQ-002 SHALL have parameter WIDTH_ADDR, default 8, RAM address width.
REQ-003 SHALL have parameter DEPTH, default 4, write-buffer entries, power of two and at least 2.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous active-low reset.
- I_St_Req  in  1  store request from store sequencer.
- I_St_Addr  in  WIDTH_ADDR  store address.
- I_St_FTk  in  FTk_t  store token; uses v, r, c, d.
- O_St_BTk  out  BTk_t  back-prop to sequencer (n, t, v, c).
- I_AccessEnd  in  1  sequencer end-of-access pulse.
- I_Ld_Busy  in  1  RAM port held by load side; stalls writes.
- O_We  out  1  RAM write enable.
- O_Addr  out  WIDTH_ADDR  RAM write address.
- O_Data  out  WIDTH_DATA  RAM write data.
- O_Count  out  $clog2(DEPTH)+1  occupied entries.
- O_Err  out  1  sticky overflow flag.
- O_Busy  out  1  block not IDLE.

Function
REQ-006 SHALL define push as I_St_Req & I_St_FTk.v in state FILL or IDLE.
- Entry stores {addr, d, c, r}.
REQ-007 SHALL accept a push when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
- Otherwise the push is dropped and O_Err is set until reset.
REQ-008 SHALL drive O_St_BTk.n combinationally = (count >= DEPTH-1), or state is DRAIN or DONE.
REQ-009 SHALL pop when the buffer is not empty and I_Ld_Busy=0.
- A pop registers O_We=1, O_Addr, and O_Data from the head entry on the next edge.
- Push-to-RAM-write latency into an empty buffer is exactly 1 cycle.
REQ-010 SHALL hold O_We=0 in any cycle with no pop.
- O_Addr and O_Data hold their last values.
REQ-011 SHALL preserve FIFO order and wrap read/write pointers modulo DEPTH.
- count changes by +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-012 SHALL implement the FSM IDLE, FILL, DRAIN, DONE:
- IDLE->FILL on accepted push.
- FILL->DRAIN on I_AccessEnd, or on an accepted push with r=1.
- DRAIN->DONE when the buffer is empty and O_We=0.
- DONE->IDLE unconditionally after 1 cycle.
REQ-013 SHALL handle a push with r=1 in IDLE by passing through FILL in one cycle and entering DRAIN.
REQ-014 SHALL ignore pushes in DRAIN and DONE.
- Ignored pushes are not errors, because n is asserted in those states.
REQ-015 SHALL pulse O_St_BTk.t for exactly the one cycle in DONE.
REQ-016 SHALL drive O_St_BTk.v=0 and O_St_BTk.c=0.
REQ-017 SHALL drive O_Busy = (state != IDLE).
REQ-018 SHALL, when I_AccessEnd and an accepted push occur in the same cycle, store the push and then enter DRAIN.

Reset
REQ-019 SHALL on reset low clear all of the following:
- state to IDLE and pointers and count to 0.
- O_We, O_Addr, O_Data and O_Err to 0.
- O_St_BTk.n, O_St_BTk.t, O_Busy and O_Count to 0.
REQ-020 SHALL on reset mid-operation discard buffered entries with no RAM write issued.

Structure
REQ-021 SHALL take FTk_t and BTk_t from pkg_en.
- The WBufState_t enum is added to pkg_en.
REQ-022 SHALL place storage in one sub-module, cram_wbuf_fifo, parameterised by width and DEPTH.
- cram_wbuf_fifo provides push, pop, full, empty and count.
- The FSM and RAM-port registers stay in the top level.

Verification
REQ-023 SHALL cover single push: addr 0x10, d 0xA5 pushed in cycle 0.
- Required: O_We=1, O_Addr=0x10, O_Data=0xA5 in cycle 1; count returns to 0.
REQ-024 SHALL cover back-pressure: I_Ld_Busy=1 while 3 pushes occur, DEPTH=4.
- Required: n=1 when count reaches 3.
- Required: after I_Ld_Busy=0, three writes in push order on consecutive cycles.
REQ-025 SHALL cover overflow: 5 pushes with I_Ld_Busy=1.
- Required: 5th push dropped, O_Err=1, count stays 4.
REQ-026 SHALL cover release: 2 pushes, the second with r=1.
- Required: state DRAIN; t pulses for 1 cycle after the last write; state returns to IDLE.
REQ-027 SHALL cover full with pop: count=4 and a push together with a pop.
- Required: push accepted, count stays 4, O_Err stays 0.
REQ-028 SHALL cover reset mid-operation: reset asserted with 3 entries buffered.
- Required: all outputs 0 immediately; no O_We after reset is released.
